// File: rtl/bcd_conv_sched.sv
// Time-shared binary-to-BCD converter for the HEX display path.
// Two level-sensitive requesters share one iterative double-dabble engine
// through round-robin arbitration. Each conversion takes one clock per input bit.
// The converted digits and a leading-zero blank mask are held for the SEG7
// decoders until the next conversion completes.
module bcd_conv_sched #(
   parameter int unsigned WIDTH  = 18,
   parameter int unsigned DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic [WIDTH-1:0]      val0,
   input  logic                  req1,
   input  logic [WIDTH-1:0]      val1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  busy,
   output logic                  done,
   output logic                  src,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     blank
);

   // The digit count must be able to hold every WIDTH-bit value.
   localparam bit DIGITS_OK = (WIDTH < 64) &&
                              ((DIGITS >= 20) || ((64'd10 ** DIGITS) > (64'd1 << WIDTH)));
   if (!DIGITS_OK) begin : g_param_check
      $error("bcd_conv_sched: DIGITS too small to represent a WIDTH-bit value");
   end

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                state_q,   state_d;
   logic [WIDTH-1:0]      shreg_q,   shreg_d;
   logic [4*DIGITS-1:0]   scratch_q, scratch_d;
   logic [CW-1:0]         cnt_q,     cnt_d;
   logic                  last_q,    last_d;    // requester served most recently
   logic                  owner_q,   owner_d;   // requester of the conversion in flight
   logic                  gnt0_q,    gnt0_d;
   logic                  gnt1_q,    gnt1_d;
   logic                  src_q,     src_d;
   logic [4*DIGITS-1:0]   bcd_q,     bcd_d;
   logic [DIGITS-1:0]     blank_q,   blank_d;

   logic                  win;
   logic [4*DIGITS-1:0]   scratch_adj;
   logic [4*DIGITS-1:0]   scratch_sh;
   logic                  unused_ovf;
   logic [DIGITS-1:0]     blank_new;
   logic                  zero_run;

   // Round-robin pick: a sole requester wins, on contention the one not served last.
   always_comb begin
      win = 1'b0;
      if (req0 && req1) begin
         win = ~last_q;
      end else begin
         win = req1;
      end
   end

   // Double-dabble correction: every digit of 5 or more gets +3 before the shift.
   always_comb begin
      scratch_adj = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end else begin
            scratch_adj[4*i +: 4] = scratch_q[4*i +: 4];
         end
      end
   end

   // Shift the corrected scratch left, pulling in the next binary bit (MSB first).
   // The bit shifted out of the top digit is always zero given the digit-count check.
   assign {unused_ovf, scratch_sh} = {scratch_adj, shreg_q[WIDTH-1]};

   // Leading-zero mask of the post-shift result; digit 0 is never blanked.
   always_comb begin
      blank_new = '0;
      zero_run  = 1'b1;
      for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
         zero_run     = zero_run & (scratch_sh[4*i +: 4] == 4'd0);
         blank_new[i] = zero_run;
      end
   end

   // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
   // The final shift and the result latch happen on the same edge, so the
   // result registers load the combinational post-shift value, not scratch_q.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      owner_d   = owner_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      src_d     = src_q;
      bcd_d     = bcd_q;
      blank_d   = blank_q;

      unique case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               shreg_d   = win ? val1 : val0;
               scratch_d = '0;
               cnt_d     = CW'(WIDTH);
               owner_d   = win;
               last_d    = win;
               gnt0_d    = ~win;
               gnt1_d    = win;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shreg_d   = shreg_q << 1;
            scratch_d = scratch_sh;
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               bcd_d   = scratch_sh;
               blank_d = blank_new;
               src_d   = owner_q;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any conversion in flight.
   // last_q resets to 1 so that requester 0 wins the first contention.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         shreg_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         owner_q   <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         src_q     <= 1'b0;
         bcd_q     <= '0;
         blank_q   <= {{(DIGITS-1){1'b1}}, 1'b0};
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         owner_q   <= owner_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         src_q     <= src_d;
         bcd_q     <= bcd_d;
         blank_q   <= blank_d;
      end
   end

   assign gnt0  = gnt0_q;
   assign gnt1  = gnt1_q;
   assign busy  = (state_q != S_IDLE);
   assign done  = (state_q == S_DONE);
   assign src   = src_q;
   assign bcd   = bcd_q;
   assign blank = blank_q;

endmodule
